// File: rtl/psram_bist_pkg.sv
// Shared types, constants and data-pattern helpers for the PSRAM self-test engine.
package psram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ISSUE = 4'd1,
    ST_WR_WAIT  = 4'd2,
    ST_RD_ISSUE = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_CHK      = 4'd5,
    ST_REPORT   = 4'd6,
    ST_NEXT_CH  = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  localparam logic [7:0] ASCII_C   = 8'h43;
  localparam logic [7:0] ASCII_E   = 8'h45;
  // Galois left-shift form of x^8+x^6+x^5+x^4+1: low terms applied when bit 7 falls out.
  localparam logic [7:0] LFSR_TAPS = 8'h71;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [7:0] pattern_byte(input logic [1:0]  mode,
                                              input logic [21:0] a,
                                              input logic [7:0]  lfsr);
    logic [7:0] b;
    b = a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    case (mode)
      2'd0:    return b;
      2'd1:    return lfsr;
      2'd2:    return ~b;
      default: return a[0] ? 8'hAA : 8'h55;
    endcase
  endfunction

endpackage

// File: rtl/ip_psram_bist_pattern.sv
// Data pattern generator: LFSR state register plus combinational mode mux.
module ip_psram_bist_pattern
  import psram_bist_pkg::*;
#(
  parameter int unsigned LEN_W = 22
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             reseed_i,
  input  logic             step_i,
  input  logic [1:0]       mode_i,
  input  logic [LEN_W-1:0] addr_i,
  output logic [7:0]       pat_c
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Reseed wins over step so a pass always begins from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pat_c = pattern_byte(mode_i, 22'(addr_i), lfsr_q);

endmodule

// File: rtl/ip_psram_bist.sv
// Multi-channel PSRAM built-in self test: write pass, verify pass, UART result record per channel.
module ip_psram_bist
  import psram_bist_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 22,
  parameter int unsigned LEN_W    = 22,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned ERR_W    = 16
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic [CHANNELS-1:0]        rd,
  output logic [CHANNELS-1:0]        wr,
  output logic [CHANNELS*ADDR_W-1:0] address,
  output logic [CHANNELS*8-1:0]      wdata,
  input  logic [CHANNELS*8-1:0]      rdata,
  input  logic [CHANNELS-1:0]        rdata_en,
  input  logic [CHANNELS-1:0]        busy,
  output logic [7:0]                 send_data,
  output logic                       send_req,
  input  logic                       send_busy,
  output logic                       running,
  output logic                       done,
  output logic                       fail,
  output logic [3:0]                 state_dbg
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [LEN_W-1:0]          addr_q, addr_d;
  logic [ERR_W-1:0]          err_q, err_d;
  logic [TO_W-1:0]           tcnt_q, tcnt_d;
  logic [7:0]                rdata_q, rdata_d;
  logic                      tout_q, tout_d;
  logic [1:0]                byte_q, byte_d;
  logic [CHANNELS-1:0]       rd_q, rd_d;
  logic [CHANNELS-1:0]       wr_q, wr_d;
  logic [CHANNELS*ADDR_W-1:0] address_q, address_d;
  logic [CHANNELS*8-1:0]     wdata_q, wdata_d;
  logic [7:0]                send_data_q, send_data_d;
  logic                      send_req_q, send_req_d;
  logic                      send_guard_q, send_guard_d;
  logic                      cmd_guard_q, cmd_guard_d;
  logic                      running_q, running_d;
  logic                      done_q, done_d;
  logic                      fail_q, fail_d;

  logic [CHANNELS-1:0] ch_sel_c;
  logic                busy_ch_c;
  logic                rdata_en_ch_c;
  logic [7:0]          rdata_ch_c;
  logic                send_ok_c;
  logic [15:0]         err16_c;
  logic                reseed_c;
  logic                step_c;
  logic [7:0]          pat_c;

  ip_psram_bist_pattern #(
    .LEN_W (LEN_W)
  ) u_pattern (
    .clk      (clk),
    .n_reset  (n_reset),
    .reseed_i (reseed_c),
    .step_i   (step_c),
    .mode_i   (mode_q),
    .addr_i   (addr_q),
    .pat_c    (pat_c)
  );

  // Active-channel view of the per-channel inputs; inactive channels are ignored.
  always_comb begin
    ch_sel_c      = '0;
    busy_ch_c     = 1'b0;
    rdata_en_ch_c = 1'b0;
    rdata_ch_c    = 8'h00;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (ch_q == CH_W'(i)) begin
        ch_sel_c[i]   = 1'b1;
        busy_ch_c     = busy[i];
        rdata_en_ch_c = rdata_en[i];
        rdata_ch_c    = rdata[i*8 +: 8];
      end
    end
  end

  // Report carries 16 bits: narrower counters zero-extend, wider ones clamp.
  always_comb begin
    err16_c = (err_q > ERR_W'(16'hFFFF)) ? 16'hFFFF : 16'(err_q);
  end

  assign send_ok_c = !send_busy && !send_req_q && !send_guard_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    err_d        = err_q;
    tcnt_d       = tcnt_q;
    rdata_d      = rdata_q;
    tout_d       = tout_q;
    byte_d       = byte_q;
    rd_d         = '0;
    wr_d         = '0;
    address_d    = address_q;
    wdata_d      = wdata_q;
    send_data_d  = send_data_q;
    send_req_d   = 1'b0;
    send_guard_d = send_req_q;
    cmd_guard_d  = |{rd_q, wr_q};
    running_d    = running_q;
    done_d       = done_q;
    fail_d       = fail_q;
    reseed_c     = 1'b0;
    step_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          ch_d      = '0;
          addr_d    = '0;
          err_d     = '0;
          fail_d    = 1'b0;
          done_d    = 1'b0;
          running_d = 1'b1;
          reseed_c  = 1'b1;
          address_d = '0;
          wdata_d   = '0;
          state_d   = ST_WR_ISSUE;
        end
      end

      ST_WR_ISSUE: begin
        if (!busy_ch_c) begin
          wr_d = ch_sel_c;
          for (int i = 0; i < int'(CHANNELS); i++) begin
            if (ch_sel_c[i]) begin
              address_d[i*ADDR_W +: ADDR_W] = ADDR_W'(addr_q);
              wdata_d[i*8 +: 8]             = pat_c;
            end
          end
          state_d = ST_WR_WAIT;
        end
      end

      // Busy is meaningless while the pulse is on the wire and during the guard cycle.
      ST_WR_WAIT: begin
        if (!(|wr_q) && !cmd_guard_q && !busy_ch_c) begin
          addr_d = addr_q + LEN_W'(1);
          if (&addr_q) begin
            reseed_c = 1'b1;
            state_d  = ST_RD_ISSUE;
          end else begin
            step_c  = 1'b1;
            state_d = ST_WR_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (!busy_ch_c) begin
          rd_d = ch_sel_c;
          for (int i = 0; i < int'(CHANNELS); i++) begin
            if (ch_sel_c[i]) begin
              address_d[i*ADDR_W +: ADDR_W] = ADDR_W'(addr_q);
            end
          end
          tcnt_d  = TO_W'(TIMEOUT);
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (rdata_en_ch_c) begin
          rdata_d = rdata_ch_c;
          tout_d  = 1'b0;
          state_d = ST_CHK;
        end else if (tcnt_q == '0) begin
          tout_d  = 1'b1;
          state_d = ST_CHK;
        end else begin
          tcnt_d = tcnt_q - TO_W'(1);
        end
      end

      ST_CHK: begin
        if ((tout_q || (rdata_q != pat_c)) && !(&err_q)) begin
          err_d = err_q + ERR_W'(1);
        end
        addr_d = addr_q + LEN_W'(1);
        step_c = 1'b1;
        if (&addr_q) begin
          byte_d  = 2'd0;
          state_d = ST_REPORT;
        end else begin
          state_d = ST_RD_ISSUE;
        end
      end

      ST_REPORT: begin
        if (send_ok_c) begin
          send_req_d = 1'b1;
          byte_d     = byte_q + 2'd1;
          case (byte_q)
            2'd0:    send_data_d = ASCII_C;
            2'd1:    send_data_d = 8'(ch_q);
            2'd2:    send_data_d = err16_c[15:8];
            default: send_data_d = err16_c[7:0];
          endcase
          if (byte_q == 2'd3) begin
            if (err_q != '0) begin
              fail_d = 1'b1;
            end
            state_d = ST_NEXT_CH;
          end
        end
      end

      // Last channel waits here until the UART can take the end marker.
      ST_NEXT_CH: begin
        err_d     = '0;
        addr_d    = '0;
        address_d = '0;
        wdata_d   = '0;
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          if (send_ok_c) begin
            send_req_d  = 1'b1;
            send_data_d = ASCII_E;
            state_d     = ST_DONE;
          end
        end else begin
          ch_d     = ch_q + CH_W'(1);
          reseed_c = 1'b1;
          state_d  = ST_WR_ISSUE;
        end
      end

      ST_DONE: begin
        running_d = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'd0;
      ch_q         <= '0;
      addr_q       <= '0;
      err_q        <= '0;
      tcnt_q       <= '0;
      rdata_q      <= 8'h00;
      tout_q       <= 1'b0;
      byte_q       <= 2'd0;
      rd_q         <= '0;
      wr_q         <= '0;
      address_q    <= '0;
      wdata_q      <= '0;
      send_data_q  <= 8'h00;
      send_req_q   <= 1'b0;
      send_guard_q <= 1'b0;
      cmd_guard_q  <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      tcnt_q       <= tcnt_d;
      rdata_q      <= rdata_d;
      tout_q       <= tout_d;
      byte_q       <= byte_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      address_q    <= address_d;
      wdata_q      <= wdata_d;
      send_data_q  <= send_data_d;
      send_req_q   <= send_req_d;
      send_guard_q <= send_guard_d;
      cmd_guard_q  <= cmd_guard_d;
      running_q    <= running_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign rd        = rd_q;
  assign wr        = wr_q;
  assign address   = address_q;
  assign wdata     = wdata_q;
  assign send_data = send_data_q;
  assign send_req  = send_req_q;
  assign running   = running_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ip_psram_bist.sv
// Scoreboard bench for ip_psram_bist: memory/UART responders, expected writes and report bytes queued per test.
module tb_ip_psram_bist;

  localparam int unsigned CH = 2;
  localparam int unsigned AW = 22;
  localparam int unsigned LW = 4;

  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CH-1:0]    rd, wr, rdata_en, busy;
  logic [CH*AW-1:0] address;
  logic [CH*8-1:0]  wdata, rdata;
  logic [7:0]       send_data;
  logic             send_req, send_busy, running, done, fail;
  logic [3:0]       state_dbg;

  logic       start_s = 1'b0;
  logic [1:0] mode_s = 2'd0;
  logic [0:0] rd_s, wr_s, busy_s, rdata_en_s;
  logic [7:0] address_s, wdata_s, rdata_s, send_data_s;
  logic       send_req_s, send_busy_s, running_s, done_s, fail_s;
  logic [3:0] state_dbg_s;

  always #5 clk = ~clk;

  ip_psram_bist #(.CHANNELS(CH), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(255), .ERR_W(16)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .mode(mode),
    .rd(rd), .wr(wr), .address(address), .wdata(wdata),
    .rdata(rdata), .rdata_en(rdata_en), .busy(busy),
    .send_data(send_data), .send_req(send_req), .send_busy(send_busy),
    .running(running), .done(done), .fail(fail), .state_dbg(state_dbg)
  );

  ip_psram_bist #(.CHANNELS(1), .ADDR_W(8), .LEN_W(5), .TIMEOUT(15), .ERR_W(4)) dut_s (
    .clk(clk), .n_reset(n_reset), .start(start_s), .mode(mode_s),
    .rd(rd_s), .wr(wr_s), .address(address_s), .wdata(wdata_s),
    .rdata(rdata_s), .rdata_en(rdata_en_s), .busy(busy_s),
    .send_data(send_data_s), .send_req(send_req_s), .send_busy(send_busy_s),
    .running(running_s), .done(done_s), .fail(fail_s), .state_dbg(state_dbg_s)
  );

  // Memory model: busy 2 cycles per command, read data 3 cycles after rd.
  logic [7:0] mem [CH][16];
  logic [1:0] bcnt [CH];
  logic [2:0] rpipe [CH];
  logic [3:0] raddr [CH];
  logic [7:0] stuck [CH];
  logic       drop_en = 1'b0;
  logic [8:0] late_cnt;
  logic [1:0] sb_cnt;

  initial begin
    stuck[0] = 8'h00;
    stuck[1] = 8'h00;
  end

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int c = 0; c < CH; c++) begin
        bcnt[c]  <= 2'd0;
        rpipe[c] <= 3'd0;
        raddr[c] <= 4'd0;
      end
      late_cnt <= 9'd0;
      sb_cnt   <= 2'd0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        rpipe[c] <= {rpipe[c][1:0],
                     rd[c] && !(drop_en && c == 0 && address[c*AW +: LW] == 4'd5)};
        if (wr[c]) begin
          mem[c][address[c*AW +: LW]] <= wdata[c*8 +: 8];
          bcnt[c] <= 2'd2;
        end else if (rd[c]) begin
          raddr[c] <= address[c*AW +: LW];
          bcnt[c]  <= 2'd2;
        end else if (bcnt[c] != 2'd0) begin
          bcnt[c] <= bcnt[c] - 2'd1;
        end
      end
      if (rd[0] && drop_en && address[LW-1:0] == 4'd5) late_cnt <= 9'd256;
      else if (late_cnt != 9'd0) late_cnt <= late_cnt - 9'd1;
      if (send_req) sb_cnt <= 2'd3;
      else if (sb_cnt != 2'd0) sb_cnt <= sb_cnt - 2'd1;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      busy[c]           = (bcnt[c] != 2'd0);
      rdata_en[c]       = rpipe[c][2] || (c == 0 && late_cnt == 9'd1);
      rdata[c*8 +: 8]   = mem[c][raddr[c]] & ~stuck[c];
    end
  end
  assign send_busy = (sb_cnt != 2'd0);

  // Small instance: never busy, answers every read next cycle with 0 (always a mismatch for mode 3).
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) rdata_en_s <= 1'b0;
    else          rdata_en_s <= rd_s;
  end
  assign busy_s      = 1'b0;
  assign rdata_s     = 8'h00;
  assign send_busy_s = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  logic [7:0]    uart_q[$];
  logic [7:0]    uart_s_q[$];
  int            wch_q[$];
  logic [AW-1:0] wad_q[$];
  logic [7:0]    wd_q[$];
  logic          wr_chk = 1'b1;
  int            rd_cnt_s = 0;
  int            wr_cnt_s = 0;

  logic [7:0] lfsr_tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h71, 8'hE2, 8'hB5, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hC1};

  // Monitors sample on the falling edge.
  always @(negedge clk) begin
    int            c;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [CH-1:0] ev;
    if (n_reset && send_req) begin
      if (uart_q.size() == 0) flag("uart_extra", send_data);
      else check("uart_byte", send_data, uart_q.pop_front());
    end
    if (n_reset && wr_chk && (|wr)) begin
      if (wch_q.size() == 0) begin
        flag("wr_extra", wr);
      end else begin
        c  = wch_q.pop_front();
        a  = wad_q.pop_front();
        d  = wd_q.pop_front();
        ev = CH'(1) << c;
        check("wr_vec", wr, ev);
        check("wr_addr", address[c*AW +: AW], a);
        check("wr_data", wdata[c*8 +: 8], d);
        check("idle_ch_fields", {rd, address[(1-c)*AW +: AW], wdata[(1-c)*8 +: 8]}, 0);
      end
    end
    if (n_reset && send_req_s) begin
      if (uart_s_q.size() == 0) flag("uart_s_extra", send_data_s);
      else check("uart_s_byte", send_data_s, uart_s_q.pop_front());
    end
    if (n_reset && rd_s[0]) rd_cnt_s++;
    if (n_reset && wr_s[0]) begin
      check("s_wr_addr", address_s, 8'(wr_cnt_s));
      check("s_wr_data", wdata_s, (wr_cnt_s % 2 == 1) ? 8'hAA : 8'h55);
      wr_cnt_s++;
    end
  end

  task automatic push_writes(input logic [1:0] m);
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < 16; a++) begin
        wch_q.push_back(c);
        wad_q.push_back(AW'(a));
        wd_q.push_back((m == 2'd1) ? lfsr_tab[a] : 8'(a));
      end
    end
  endtask

  task automatic push_report(input logic [15:0] e0, input logic [15:0] e1);
    uart_q.push_back(8'h43); uart_q.push_back(8'h00); uart_q.push_back(e0[15:8]); uart_q.push_back(e0[7:0]);
    uart_q.push_back(8'h43); uart_q.push_back(8'h01); uart_q.push_back(e1[15:8]); uart_q.push_back(e1[7:0]);
    uart_q.push_back(8'h45);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("running_after_start", running, 1'b1);
    check("done_cleared", done, 1'b0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag({name, "_done_timeout"}, n);
  endtask

  task automatic end_check(input logic exp_fail);
    check("fail_flag", fail, exp_fail);
    check("done_flag", done, 1'b1);
    check("running_low", running, 1'b0);
    check("state_idle", state_dbg, 4'd0);
    check("uart_drained", uart_q.size(), 0);
    check("wr_drained", wch_q.size(), 0);
  endtask

  task automatic wait_state_pos(input logic [3:0] s, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_dbg != s && n < budget);
    if (state_dbg != s) flag("state_wait_timeout", state_dbg);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctl", {rd, wr, send_req, running, done, fail, state_dbg}, 0);
    check("reset_bus", |{address, wdata, send_data}, 1'b0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: good memory, mode 0
    push_writes(2'd0);
    push_report(16'd0, 16'd0);
    pulse_start(2'd0);
    wait_done("t1", 5000);
    end_check(1'b0);

    // 2: channel 1 data bit 3 stuck low
    stuck[1] = 8'h08;
    push_writes(2'd0);
    push_report(16'd0, 16'd8);
    pulse_start(2'd0);
    wait_done("t2", 5000);
    end_check(1'b1);
    stuck[1] = 8'h00;

    // 3: LFSR pattern, good memory
    push_writes(2'd1);
    push_report(16'd0, 16'd0);
    pulse_start(2'd1);
    wait_done("t3", 5000);
    end_check(1'b0);

    // 4: channel 0 read at address 5 times out, late pulse afterwards
    drop_en = 1'b1;
    push_writes(2'd0);
    push_report(16'd1, 16'd0);
    pulse_start(2'd0);
    wait_done("t4", 8000);
    end_check(1'b1);
    drop_en = 1'b0;

    // 5: reset mid write-wait and mid report
    wr_chk = 1'b0;
    pulse_start(2'd0);
    wait_state_pos(4'd2, 200);
    n_reset = 1'b0;
    #1;
    check("rst_wrwait_outs", {rd, wr, send_req, running, done}, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wrwait_idle", state_dbg, 4'd0);
    pulse_start(2'd0);
    wait_state_pos(4'd6, 3000);
    n_reset = 1'b0;
    #1;
    check("rst_report_outs", {rd, wr, send_req, running, done}, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_report_idle", {state_dbg, running, done, fail}, 0);
    wr_chk = 1'b1;

    // 6: saturating 4-bit error count, restart attempt while running
    uart_s_q.push_back(8'h43); uart_s_q.push_back(8'h00);
    uart_s_q.push_back(8'h00); uart_s_q.push_back(8'h0F); uart_s_q.push_back(8'h45);
    @(negedge clk);
    mode_s  = 2'd3;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (10) @(negedge clk);
    mode_s  = 2'd0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check("s_running", running_s, 1'b1);
    begin
      int n = 0;
      while (!done_s && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!done_s) flag("t6_done_timeout", n);
    end
    check("s_rd_count", rd_cnt_s, 32);
    check("s_wr_count", wr_cnt_s, 32);
    check("s_fail", fail_s, 1'b1);
    check("s_uart_drained", uart_s_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
